// File: rtl/mdu_ctrl_if.sv
// HI/LO unit bundle between the E/D pipeline stages (master) and mdu_ctrl (slave).
interface mdu_ctrl_if;
    logic        op_valid;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    modport master (
        output op_valid, md_op, a, b, d_md,
        input  busy, hi, lo, stall_md
    );

    modport slave (
        input  op_valid, md_op, a, b, d_md,
        output busy, hi, lo, stall_md
    );
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: mult/div sequencer owning HI/LO; result commits N+1 edges after start (N = MULT/DIV_CYCLES).
// No backpressure: stall_md holds D while busy; macro MDU_MADD_EN adds madd/maddu (ops 7/8).
module mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    mdu_ctrl_if.slave  mdu
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [63:0] pend, pend_nxt;
    logic        pend_wr, pend_wr_nxt;
    logic [31:0] hi_q, lo_q, hi_nxt, lo_nxt;

    logic        is_mult, is_div, is_madd, is_mc;
    logic [63:0] prod_s, prod_u, res;
    logic [31:0] abs_a, abs_b, abs_b_nz, b_nz;
    logic [31:0] uq, ur, q_s, r_s, q_u, r_u;

    assign is_mult = (mdu.md_op == 4'd1) || (mdu.md_op == 4'd2);
    assign is_div  = (mdu.md_op == 4'd3) || (mdu.md_op == 4'd4);
`ifdef MDU_MADD_EN
    assign is_madd = (mdu.md_op == 4'd7) || (mdu.md_op == 4'd8);
`else
    assign is_madd = 1'b0;
`endif
    assign is_mc = is_mult | is_div | is_madd;

    assign prod_s = $signed({{32{mdu.a[31]}}, mdu.a}) * $signed({{32{mdu.b[31]}}, mdu.b});
    assign prod_u = {32'd0, mdu.a} * {32'd0, mdu.b};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as lo=0x80000000, hi=0.
    // Zero divisors are replaced by 1 only to keep the datapath defined; the result is never committed.
    assign abs_a    = mdu.a[31] ? (32'd0 - mdu.a) : mdu.a;
    assign abs_b    = mdu.b[31] ? (32'd0 - mdu.b) : mdu.b;
    assign abs_b_nz = (mdu.b == 32'd0) ? 32'd1 : abs_b;
    assign b_nz     = (mdu.b == 32'd0) ? 32'd1 : mdu.b;
    assign uq       = abs_a / abs_b_nz;
    assign ur       = abs_a % abs_b_nz;
    assign q_s      = (mdu.a[31] ^ mdu.b[31]) ? (32'd0 - uq) : uq;
    assign r_s      = mdu.a[31] ? (32'd0 - ur) : ur;
    assign q_u      = mdu.a / b_nz;
    assign r_u      = mdu.a % b_nz;

    always_comb begin
        res = 64'd0;
        case (mdu.md_op)
            4'd1:    res = prod_s;
            4'd2:    res = prod_u;
            4'd3:    res = {r_s, q_s};
            4'd4:    res = {r_u, q_u};
`ifdef MDU_MADD_EN
            4'd7:    res = {hi_q, lo_q} + prod_s;
            4'd8:    res = {hi_q, lo_q} + prod_u;
`endif
            default: res = 64'd0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = pend;
        pend_wr_nxt = pend_wr;
        hi_nxt      = hi_q;
        lo_nxt      = lo_q;
        case (state)
            IDLE: begin
                if (mdu.op_valid) begin
                    if (is_mc) begin
                        state_nxt   = RUN;
                        cnt_nxt     = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                        pend_nxt    = res;
                        pend_wr_nxt = !(is_div && (mdu.b == 32'd0));
                    end else if (mdu.md_op == 4'd5) begin
                        hi_nxt = mdu.a;
                    end else if (mdu.md_op == 4'd6) begin
                        lo_nxt = mdu.a;
                    end
                end
            end
            RUN: begin
                if (cnt == 4'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                    if (pend_wr) begin
                        hi_nxt = pend[63:32];
                        lo_nxt = pend[31:0];
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_wr <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend    <= pend_nxt;
            pend_wr <= pend_wr_nxt;
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
        end
    end

    assign mdu.busy     = (state == RUN);
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;
    assign mdu.stall_md = mdu.d_md & ((state == RUN) | (mdu.op_valid & is_mc));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: latency, arithmetic, HI/LO moves, stall generation, mid-op reset, madd option.
module tb_mdu_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_ctrl_if mif();

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one op for a single cycle; the unit must be idle when it is presented.
    task automatic start(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb,
                         input logic exp_stall, input string tag);
        mif.op_valid = 1'b1;
        mif.md_op    = op;
        mif.a        = aa;
        mif.b        = bb;
        #1;
        chk({tag, "_idle_at_start"}, {31'd0, mif.busy}, 32'd0);
        chk({tag, "_stall_start"}, {31'd0, mif.stall_md}, {31'd0, exp_stall});
        next_cyc();
        mif.op_valid = 1'b0;
        mif.md_op    = 4'd0;
    endtask

    task automatic run_busy(input int n, input logic exp_stall, input string tag);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, mif.busy}, 32'd1);
            chk($sformatf("%s_stall%0d", tag, i), {31'd0, mif.stall_md}, {31'd0, exp_stall});
            next_cyc();
        end
        chk({tag, "_busy_fall"}, {31'd0, mif.busy}, 32'd0);
        chk({tag, "_stall_fall"}, {31'd0, mif.stall_md}, 32'd0);
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] val, input string tag);
        mif.op_valid = 1'b1;
        mif.md_op    = op;
        mif.a        = val;
        #1;
        chk({tag, "_no_stall"}, {31'd0, mif.stall_md}, 32'd0);
        next_cyc();
        mif.op_valid = 1'b0;
        mif.md_op    = 4'd0;
        chk({tag, "_no_busy"}, {31'd0, mif.busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        mif.op_valid = 1'b0;
        mif.md_op    = 4'd0;
        mif.a        = 32'd0;
        mif.b        = 32'd0;
        mif.d_md     = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b0;
        #1;
        chk("rst_busy",  {31'd0, mif.busy}, 32'd0);
        chk("rst_hi",    mif.hi, 32'd0);
        chk("rst_lo",    mif.lo, 32'd0);
        chk("rst_stall", {31'd0, mif.stall_md}, 32'd0);

        // mult -2 * 3 = -6
        start(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, "mult");
        chk("mult_hi_no_fwd", mif.hi, 32'd0);
        chk("mult_lo_no_fwd", mif.lo, 32'd0);
        run_busy(5, 1'b0, "mult");
        chk("mult_hi", mif.hi, 32'hFFFFFFFF);
        chk("mult_lo", mif.lo, 32'hFFFFFFFA);

        // multu 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001
        start(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu");
        run_busy(5, 1'b0, "multu");
        chk("multu_hi", mif.hi, 32'hFFFFFFFE);
        chk("multu_lo", mif.lo, 32'h00000001);

        // divu 100 / 7 = 14 r 2
        start(4'd4, 32'd100, 32'd7, 1'b0, "divu");
        run_busy(10, 1'b0, "divu");
        chk("divu_hi", mif.hi, 32'd2);
        chk("divu_lo", mif.lo, 32'd14);

        // div -100 / 7 = -14 r -2
        start(4'd3, 32'hFFFFFF9C, 32'd7, 1'b0, "div");
        run_busy(10, 1'b0, "div");
        chk("div_hi", mif.hi, 32'hFFFFFFFE);
        chk("div_lo", mif.lo, 32'hFFFFFFF2);

        // signed overflow
        start(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, "divovf");
        run_busy(10, 1'b0, "divovf");
        chk("divovf_hi", mif.hi, 32'd0);
        chk("divovf_lo", mif.lo, 32'h80000000);

        // mthi/mtlo preload, then divide by zero leaves them intact
        mt(4'd5, 32'h11, "mthi");
        chk("mthi_hi", mif.hi, 32'h11);
        mt(4'd6, 32'h22, "mtlo");
        chk("mtlo_lo", mif.lo, 32'h22);
        chk("mtlo_hi_kept", mif.hi, 32'h11);
        start(4'd3, 32'd5, 32'd0, 1'b0, "div0");
        run_busy(10, 1'b0, "div0");
        chk("div0_hi", mif.hi, 32'h11);
        chk("div0_lo", mif.lo, 32'h22);

        // stall generation with an HI/LO instruction held in D
        mif.d_md = 1'b1;
        #1;
        chk("dmd_idle_no_stall", {31'd0, mif.stall_md}, 32'd0);
        mt(4'd5, 32'h33, "mthi_dmd");
        chk("mthi_dmd_hi", mif.hi, 32'h33);
        start(4'd1, 32'd7, 32'd6, 1'b1, "stall");
        run_busy(5, 1'b1, "stall");
        chk("stall_hi", mif.hi, 32'd0);
        chk("stall_lo", mif.lo, 32'd42);

        // undefined op codes have no effect
        start(4'd9, 32'd1, 32'd1, 1'b0, "op9");
        chk("op9_busy", {31'd0, mif.busy}, 32'd0);
        start(4'd15, 32'd1, 32'd1, 1'b0, "op15");
        chk("op15_busy", {31'd0, mif.busy}, 32'd0);
        chk("undef_lo", mif.lo, 32'd42);
        mif.d_md = 1'b0;

        // reset in the third busy cycle of a mult discards the pending result
        start(4'd1, 32'd3, 32'd4, 1'b0, "rstmid");
        next_cyc();
        next_cyc();
        chk("rstmid_busy3", {31'd0, mif.busy}, 32'd1);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, mif.busy}, 32'd0);
        chk("rstmid_hi", mif.hi, 32'd0);
        chk("rstmid_lo", mif.lo, 32'd0);
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            chk($sformatf("rstmid_late_busy%0d", i), {31'd0, mif.busy}, 32'd0);
            chk($sformatf("rstmid_late_lo%0d", i), mif.lo, 32'd0);
            chk($sformatf("rstmid_late_hi%0d", i), mif.hi, 32'd0);
        end

        // madd {0, 0xFFFFFFFF} + 1*1
        mt(4'd5, 32'd0, "madd_prehi");
        mt(4'd6, 32'hFFFFFFFF, "madd_prelo");
        mif.d_md = 1'b1;
`ifdef MDU_MADD_EN
        start(4'd7, 32'd1, 32'd1, 1'b1, "madd");
        run_busy(5, 1'b1, "madd");
        chk("madd_hi", mif.hi, 32'd1);
        chk("madd_lo", mif.lo, 32'd0);
`else
        start(4'd7, 32'd1, 32'd1, 1'b0, "madd_off");
        chk("madd_off_busy", {31'd0, mif.busy}, 32'd0);
        chk("madd_off_stall", {31'd0, mif.stall_md}, 32'd0);
        repeat (6) next_cyc();
        chk("madd_off_busy_late", {31'd0, mif.busy}, 32'd0);
        chk("madd_off_hi", mif.hi, 32'd0);
        chk("madd_off_lo", mif.lo, 32'hFFFFFFFF);
`endif
        mif.d_md = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multi-cycle multiply/divide unit and its HI/LO register pair in the 5-stage MIPS pipeline.
- Accepts an HI/LO operation from the E stage and holds `busy` for a fixed latency, then commits the result to HI/LO.
- Generates `stall_md`, which is ORed into the D-stage stall from the hazard unit whenever the instruction in D needs HI/LO while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, number of busy cycles for mult/multu (and madd/maddu); legal range 1..15.
- DIV_CYCLES, 10, number of busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; one clock; clears all state.
- op_valid  input  1  E-stage instruction is an HI/LO-writing op; single-cycle qualifier for md_op.
- md_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, others none.
- a  input  32  forwarded rs value from E stage.
- b  input  32  forwarded rt value from E stage.
- d_md  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo/madd/maddu.
- busy  output  1  multi-cycle operation in progress.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.
- stall_md  output  1  stall request to the D stage.

Behaviour:
- Reset: busy=0, hi=0, lo=0, state=IDLE, counter=0. Reset wins over all other inputs in the same cycle, including mid-operation: the pending result is discarded.
- FSM states: IDLE and RUN.
  - IDLE -> RUN on op_valid with md_op in {1,2,3,4}, or {7,8} when the feature is enabled.
    - At that edge, latch the full 64-bit result into an internal pending register.
    - Load counter with MULT_CYCLES or DIV_CYCLES.
  - RUN: decrement the counter each cycle. When counter==1, next edge: hi/lo <= pending, state=IDLE.
- Timing: op_valid at cycle t gives busy=1 in cycles t+1..t+N, where N is the latency. New hi/lo are visible from cycle t+N+1, and busy=0 in that same cycle.
- mthi/mtlo: on op_valid, write a into hi (op 5) or lo (op 6) at the next edge. No busy is raised. Accepted only in IDLE.
- Arithmetic:
  - mult: signed 32x32->64, hi=product[63:32], lo=product[31:0].
  - multu: unsigned 32x32->64, same split.
  - div: signed, lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned, lo=quotient, hi=remainder.
- Divide by zero (b==0): full busy latency still elapses; hi/lo are left unchanged at commit.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- op_valid while busy=1: ignored, no state change. The stall path guarantees this cannot occur; the bench flags it as an error.
- op_valid with md_op 0 or an undefined code: no effect.
- stall_md = d_md & (busy | (op_valid & md_op starts a multi-cycle op)). Purely combinational from the current inputs and state.
  - Covers the back-to-back case where the E-stage op starts in the same cycle D decodes an HI/LO instruction.
  - mthi/mtlo in E do not stall D, because they commit before D reaches E.
- hi/lo are read combinationally by the E-stage mfhi/mflo path. No forwarding of the pending value before commit.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - md_op 7 (madd) computes {hi,lo} + signed(a)*signed(b).
  - md_op 8 (maddu) computes {hi,lo} + unsigned(a)*unsigned(b).
  - Both use MULT_CYCLES. The accumulate base is hi/lo as sampled at the start edge; 64-bit wrap-around.
- Undefined: codes 7 and 8 are treated as none. busy is not raised and stall_md ignores them.

Test Plan:
- reset, then op_valid, md_op=1, a=0xFFFFFFFE (-2), b=3 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA, busy=0.
- md_op=4, a=100, b=7 -> busy 10 cycles; hi=2, lo=14. Repeat with md_op=3, a=0xFFFFFF9C (-100), b=7 -> hi=0xFFFFFFFE, lo=0xFFFFFFF2.
- Preload hi=0x11, lo=0x22 via mthi/mtlo, then div with b=0 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged. Also check mthi raises no busy cycle.
- Start mult with d_md=1 held -> stall_md=1 in the start cycle and all 5 busy cycles; stall_md=0 in the cycle busy falls.
- Assert reset at the 3rd busy cycle of a mult -> next cycle busy=0, hi=lo=0, no late commit in any later cycle.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=1, lo=0 after 5 cycles. Undefined: the same stimulus leaves busy=0 and hi/lo unchanged.
